// File: rtl/snake_pkg.sv
// Shared types and constants for the SRAM arbiter and the rest of the game slice.
package snake_pkg;

  localparam int SRAM_AW = 18;
  localparam int SRAM_DW = 16;

  // Cell values that game logic stores in the playfield.
  localparam logic [SRAM_DW-1:0] BORDER_VALUE    = 16'hFFFF;
  localparam logic [SRAM_DW-1:0] OBJECTIVE_VALUE = 16'hFFFE;

  // IDLE, RD_D and TURN are the decision states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_D = 3'd2,
    ST_WR_A = 3'd3,
    ST_WR_D = 3'd4,
    ST_TURN = 3'd5
  } state_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// Display/game request channels plus the SRAM control pins.
// The SRAM data bus is bidirectional and stays a plain port on the arbiter.
interface sram_arbiter_if;
  import snake_pkg::*;

  logic               disp_req;
  logic [SRAM_AW-1:0] disp_addr;
  logic [SRAM_DW-1:0] disp_rdata;
  logic               disp_valid;

  logic               game_req;
  logic               game_we;
  logic [SRAM_AW-1:0] game_addr;
  logic [SRAM_DW-1:0] game_wdata;
  logic               game_ack;
  logic [SRAM_DW-1:0] game_rdata;

  logic [SRAM_AW-1:0] sram_addr;
  logic               sram_we_n;
  logic               sram_oe_n;

  // Arbiter side.
  modport slave (
    input  disp_req, disp_addr, game_req, game_we, game_addr, game_wdata,
    output disp_rdata, disp_valid, game_ack, game_rdata,
    output sram_addr, sram_we_n, sram_oe_n
  );

  // Client / board side.
  modport master (
    output disp_req, disp_addr, game_req, game_we, game_addr, game_wdata,
    input  disp_rdata, disp_valid, game_ack, game_rdata,
    input  sram_addr, sram_we_n, sram_oe_n
  );

endinterface

// File: rtl/sram_io_pad.sv
// SRAM data-bus pad: tri-state write driver and read-data capture registers.
module sram_io_pad
  import snake_pkg::*;
(
  input  logic               clk_25_2,
  input  logic               rst,
  input  logic               drive,
  input  logic [SRAM_DW-1:0] wdata,
  input  logic               cap_disp,
  input  logic               cap_game,
  inout  wire  [SRAM_DW-1:0] dq,
  output logic [SRAM_DW-1:0] disp_rdata,
  output logic [SRAM_DW-1:0] game_rdata
);

  // Drive enable and data both come straight from registers, so the bus never glitches.
  assign dq = drive ? wdata : 'z;

  // Sample the bus at the edge that closes RD_D into the owner's data register.
  always_ff @(posedge clk_25_2) begin
    if (rst) begin
      disp_rdata <= '0;
      game_rdata <= '0;
    end else begin
      if (cap_disp) disp_rdata <= dq;
      if (cap_game) game_rdata <= dq;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-client SRAM arbiter: the display reads with priority, and game-logic
// reads and writes get a bounded wait before they are forced through.
module sram_arbiter
  import snake_pkg::*;
#(
  parameter int GAME_MAX_WAIT = 8
) (
  input  logic               clk_25_2,
  input  logic               rst,
  sram_arbiter_if.slave      bus,
  inout  wire  [SRAM_DW-1:0] sram_dq
);

  localparam logic [3:0] MAX_WAIT = 4'(GAME_MAX_WAIT);

  state_t             state;
  logic               own_game;   // current access belongs to game logic
  logic [3:0]         wait_cnt;   // decisions the pending game request has lost
  logic               dq_drive;
  logic [SRAM_DW-1:0] wdata_q;

  logic is_dec;
  logic game_live;
  logic grant_disp;
  logic grant_game;
  logic cap_disp;
  logic cap_game;

  // Grant decision. The game request is masked while its own ack is pending
  // (RD_D of a game read, and TURN), so a held request is not granted twice.
  always_comb begin
    is_dec     = 1'b0;
    game_live  = 1'b0;
    grant_disp = 1'b0;
    grant_game = 1'b0;
    is_dec     = (state == ST_IDLE) || (state == ST_RD_D) || (state == ST_TURN);
    game_live  = bus.game_req &&
                 !(((state == ST_RD_D) && own_game) || (state == ST_TURN));
    grant_disp = is_dec && bus.disp_req && (!game_live || (wait_cnt < MAX_WAIT));
    grant_game = is_dec && !grant_disp && game_live;
  end

  // Read capture strobes for the edge that ends RD_D.
  always_comb begin
    cap_disp = 1'b0;
    cap_game = 1'b0;
    cap_disp = (state == ST_RD_D) && !own_game;
    cap_game = (state == ST_RD_D) &&  own_game;
  end

  // Arbiter FSM with registered SRAM controls, handshake pulses and wait counter.
  always_ff @(posedge clk_25_2) begin
    if (rst) begin
      state          <= ST_IDLE;
      own_game       <= 1'b0;
      wait_cnt       <= 4'd0;
      dq_drive       <= 1'b0;
      wdata_q        <= '0;
      bus.sram_addr  <= '0;
      bus.sram_we_n  <= 1'b1;
      bus.sram_oe_n  <= 1'b1;
      bus.disp_valid <= 1'b0;
      bus.game_ack   <= 1'b0;
    end else begin
      bus.disp_valid <= 1'b0;
      bus.game_ack   <= 1'b0;

      case (state)
        ST_RD_A: begin
          state <= ST_RD_D;
        end

        ST_WR_A: begin
          state <= ST_WR_D;
        end

        ST_WR_D: begin
          state         <= ST_TURN;
          bus.sram_we_n <= 1'b1;
          dq_drive      <= 1'b0;
          bus.game_ack  <= 1'b1;
        end

        default: begin
          // A read finishing here signals its owner one cycle later,
          // alongside the captured data.
          if (state == ST_RD_D) begin
            if (own_game) bus.game_ack   <= 1'b1;
            else          bus.disp_valid <= 1'b1;
          end

          if (game_live && grant_disp) begin
            if (wait_cnt != 4'hF) wait_cnt <= wait_cnt + 4'd1;
          end else if (grant_game || !game_live) begin
            wait_cnt <= 4'd0;
          end

          if (grant_disp) begin
            state         <= ST_RD_A;
            own_game      <= 1'b0;
            bus.sram_addr <= bus.disp_addr;
            bus.sram_oe_n <= 1'b0;
            bus.sram_we_n <= 1'b1;
            dq_drive      <= 1'b0;
          end else if (grant_game) begin
            own_game      <= 1'b1;
            bus.sram_addr <= bus.game_addr;
            if (bus.game_we) begin
              state         <= ST_WR_A;
              wdata_q       <= bus.game_wdata;
              bus.sram_oe_n <= 1'b1;
              bus.sram_we_n <= 1'b0;
              dq_drive      <= 1'b1;
            end else begin
              state         <= ST_RD_A;
              bus.sram_oe_n <= 1'b0;
              bus.sram_we_n <= 1'b1;
              dq_drive      <= 1'b0;
            end
          end else begin
            state         <= ST_IDLE;
            bus.sram_oe_n <= 1'b1;
            bus.sram_we_n <= 1'b1;
            dq_drive      <= 1'b0;
          end
        end
      endcase
    end
  end

  sram_io_pad u_pad (
    .clk_25_2   (clk_25_2),
    .rst        (rst),
    .drive      (dq_drive),
    .wdata      (wdata_q),
    .cap_disp   (cap_disp),
    .cap_game   (cap_game),
    .dq         (sram_dq),
    .disp_rdata (bus.disp_rdata),
    .game_rdata (bus.game_rdata)
  );

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with an asynchronous-read SRAM model.
module tb_sram_arbiter;
  import snake_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #20 clk = ~clk;

  sram_arbiter_if bus ();
  wire [15:0] sram_dq;

  sram_arbiter #(.GAME_MAX_WAIT(8)) dut (
    .clk_25_2 (clk),
    .rst      (rst),
    .bus      (bus),
    .sram_dq  (sram_dq)
  );

  // SRAM model: 1K words, asynchronous read while oe_n low, write on clock while we_n low.
  logic [15:0] mem    [0:1023];
  logic [15:0] shadow [0:1023];

  function automatic logic [15:0] init_val(input int i);
    return 16'hA000 ^ 16'(i * 7);
  endfunction

  assign sram_dq = bus.sram_oe_n ? 16'hzzzz : mem[bus.sram_addr[9:0]];

  always @(posedge clk) begin
    if (!bus.sram_we_n) mem[bus.sram_addr[9:0]] <= sram_dq;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait for game_ack on falling edges; lat = cycles waited, 0 on timeout.
  task automatic wait_ack(input int limit, output int lat);
    lat = 0;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (bus.game_ack) begin
        lat = c;
        return;
      end
    end
  endtask

  initial begin
    #1200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, we_low, got, dv, maxw, acks, found, bad_bus, rd_bad, timeouts, age, pending, a;
    logic [31:0] ack_state;

    for (int i = 0; i < 1024; i++) mem[i] = init_val(i);
    bus.disp_req   = 1'b0;
    bus.disp_addr  = '0;
    bus.game_req   = 1'b0;
    bus.game_we    = 1'b0;
    bus.game_addr  = '0;
    bus.game_wdata = '0;

    // ---- reset state ----
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_state",      32'(dut.state), 32'(ST_IDLE));
    chk("rst_we_n",       32'(bus.sram_we_n), 32'd1);
    chk("rst_oe_n",       32'(bus.sram_oe_n), 32'd1);
    chk("rst_addr",       32'(bus.sram_addr), 32'd0);
    chk("rst_disp_valid", 32'(bus.disp_valid), 32'd0);
    chk("rst_game_ack",   32'(bus.game_ack), 32'd0);
    chk("rst_disp_rdata", 32'(bus.disp_rdata), 32'd0);
    chk("rst_game_rdata", 32'(bus.game_rdata), 32'd0);
    chk("rst_wait_cnt",   32'(dut.wait_cnt), 32'd0);
    chk("rst_dq_drive",   32'(dut.dq_drive), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // ---- display-only streaming: one read per 2 cycles, first valid at N+3 ----
    bus.disp_req  = 1'b1;
    bus.disp_addr = 18'd0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);   // RD_A of read j
      chk("disp_sram_addr", 32'(bus.sram_addr), 32'(j));
      chk("disp_oe_n_rda",  32'(bus.sram_oe_n), 32'd0);
      if (j == 0) begin
        chk("disp_valid_first", 32'(bus.disp_valid), 32'd0);
      end else begin
        chk("disp_valid_pulse", 32'(bus.disp_valid), 32'd1);
        chk("disp_rdata",       32'(bus.disp_rdata), 32'(init_val(j - 1)));
      end
      bus.disp_addr = 18'(j + 1);
      @(negedge clk);   // RD_D of read j
      chk("disp_valid_gap", 32'(bus.disp_valid), 32'd0);
    end
    bus.disp_req = 1'b0;
    @(negedge clk);
    chk("disp_valid_last", 32'(bus.disp_valid), 32'd1);
    chk("disp_rdata_last", 32'(bus.disp_rdata), 32'(init_val(5)));
    @(negedge clk);
    chk("disp_idle", 32'(dut.state), 32'(ST_IDLE));

    // ---- game write 0x00C8 <= 0x0005 ----
    bus.game_req   = 1'b1;
    bus.game_we    = 1'b1;
    bus.game_addr  = 18'h000C8;
    bus.game_wdata = 16'h0005;
    lat = 0; we_low = 0; got = 0; ack_state = '0;
    for (int c = 1; c <= 10 && got == 0; c++) begin
      @(negedge clk);
      if (!bus.sram_we_n) we_low++;
      if (c == 1) begin
        chk("wr_a_dq",    32'(sram_dq), 32'h5);
        chk("wr_a_drive", 32'(dut.dq_drive), 32'd1);
      end
      if (bus.game_ack) begin
        got = 1;
        lat = c;
        ack_state = 32'(dut.state);
        chk("wr_turn_drive", 32'(dut.dq_drive), 32'd0);
        bus.game_req = 1'b0;
      end
    end
    chk("wr_ack_seen",    32'(got), 32'd1);
    chk("wr_ack_latency", 32'(lat), 32'd3);
    chk("wr_ack_state",   ack_state, 32'(ST_TURN));
    chk("wr_we_low_cyc",  32'(we_low), 32'd2);
    @(negedge clk);
    chk("wr_ack_single", 32'(bus.game_ack), 32'd0);
    chk("wr_mem",        32'(mem[200]), 32'h5);

    // ---- game read 0x00C8, request held after ack, then dropped in RD_A ----
    bus.game_we  = 1'b0;
    bus.game_req = 1'b1;
    wait_ack(10, lat);
    chk("rd_ack_latency", 32'(lat), 32'd3);
    chk("rd_game_rdata",  32'(bus.game_rdata), 32'h5);
    @(negedge clk);
    chk("rd_rereq_state", 32'(dut.state), 32'(ST_RD_A));
    chk("rd_ack_single",  32'(bus.game_ack), 32'd0);
    bus.game_req = 1'b0;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.game_ack) acks++;
    end
    chk("viol_ack_count", 32'(acks), 32'd1);
    chk("viol_rdata",     32'(bus.game_rdata), 32'h5);

    // ---- contention: 8 display grants, then the game read ----
    bus.game_addr = 18'h00010;
    bus.game_we   = 1'b0;
    bus.disp_addr = 18'h00033;
    bus.disp_req  = 1'b1;
    bus.game_req  = 1'b1;
    dv = 0; maxw = 0; got = 0;
    for (int c = 1; c <= 60 && got == 0; c++) begin
      @(negedge clk);
      if (int'(dut.wait_cnt) > maxw) maxw = int'(dut.wait_cnt);
      if (bus.game_ack) begin
        got = 1;
        chk("cont_game_rdata", 32'(bus.game_rdata), 32'(init_val(16)));
        chk("cont_wait_clear", 32'(dut.wait_cnt), 32'd0);
        bus.game_req = 1'b0;
        bus.disp_req = 1'b0;
      end else if (bus.disp_valid) begin
        dv++;
      end
    end
    chk("cont_game_ack",   32'(got), 32'd1);
    chk("cont_disp_grant", 32'(dv), 32'd8);
    chk("cont_wait_max",   32'(maxw), 32'd8);
    repeat (4) @(negedge clk);

    // ---- reset during WR_D ----
    bus.game_we    = 1'b1;
    bus.game_addr  = 18'h00020;
    bus.game_wdata = 16'h1234;
    bus.game_req   = 1'b1;
    found = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (dut.state == ST_WR_D) begin
        found = 1;
        break;
      end
    end
    chk("rstw_found_wrd", 32'(found), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstw_state", 32'(dut.state), 32'(ST_IDLE));
    chk("rstw_we_n",  32'(bus.sram_we_n), 32'd1);
    chk("rstw_drive", 32'(dut.dq_drive), 32'd0);
    chk("rstw_ack",   32'(bus.game_ack), 32'd0);
    rst = 1'b0;
    bus.game_req = 1'b0;
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.game_ack) acks++;
    end
    chk("rstw_no_ack", 32'(acks), 32'd0);

    // ---- random interleaving: bus safety, game read scoreboard, bounded wait ----
    for (int i = 0; i < 1024; i++) shadow[i] = mem[i];
    bad_bus = 0; rd_bad = 0; timeouts = 0; acks = 0; age = 0; pending = 0; a = 0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      if (!bus.sram_we_n && !bus.sram_oe_n) bad_bus++;
      if (dut.dq_drive && !bus.sram_oe_n) bad_bus++;
      if (pending != 0) begin
        if (bus.game_ack) begin
          acks++;
          if (bus.game_we) shadow[a] = bus.game_wdata;
          else if (bus.game_rdata !== shadow[a]) rd_bad++;
          pending = 0;
          age = 0;
          bus.game_req = 1'b0;
        end else begin
          age++;
          if (age > 40) begin
            timeouts++;
            pending = 0;
            age = 0;
            bus.game_req = 1'b0;
          end
        end
      end else if ($urandom_range(0, 2) == 0) begin
        a = int'($urandom_range(0, 1023));
        bus.game_we    = ($urandom_range(0, 1) == 1);
        bus.game_addr  = 18'(a);
        bus.game_wdata = 16'($urandom_range(0, 65535));
        bus.game_req   = 1'b1;
        pending = 1;
      end
      bus.disp_req  = ($urandom_range(0, 3) != 0);
      bus.disp_addr = 18'($urandom_range(0, 1023));
    end
    chk("rand_bus_safety", 32'(bad_bus), 32'd0);
    chk("rand_rd_data",    32'(rd_bad), 32'd0);
    chk("rand_timeouts",   32'(timeouts), 32'd0);
    chk("rand_acks_seen",  32'(acks > 100), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
